// File: rtl/disp_pkg.sv
// ============================================================================
//  Module   : disp_pkg
//  Purpose  : Shared constants for the seven-segment scan controller.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package disp_pkg;

   localparam int DIG_W = 3;
   localparam int NDIG  = 8;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [6:0] SEG_OFF   = 7'h7F;

   // Active-low gfedcba patterns, indexed by nibble value
   localparam logic [6:0] HEX_SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

`default_nettype wire

// File: rtl/hex7seg.sv
// ============================================================================
//  Module   : hex7seg
//  Purpose  : Combinational hex nibble to active-low 7-segment pattern.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hex7seg
   import disp_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] pat
);

   assign pat = HEX_SEG[nib];

endmodule

`default_nettype wire

// File: rtl/scan_ctrl.sv
// ============================================================================
//  Module   : scan_ctrl
//  Purpose  : 8-digit multiplexed seven-segment scanner with a double-buffered
//             32-bit value that is swapped in only at frame boundaries.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module scan_ctrl
   import disp_pkg::*;
#(
   parameter int DIV = 50000
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      din,
   input  logic             ld,
   input  logic [7:0]       dp_in,
   input  logic             blz,
   output logic [DIG_W-1:0] cd,
   output logic [7:0]       seg,
   output logic             ack
);

   localparam int                PCNT_W   = $clog2(DIV);
   localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(DIV - 1);
   localparam logic [DIG_W-1:0]  LAST_CD  = DIG_W'(NDIG - 1);

   logic [PCNT_W-1:0] r_pcnt;
   logic [31:0]       r_pend;
   logic [31:0]       r_disp;
   logic [7:0]        r_pdp;
   logic [7:0]        r_dp_disp;
   logic              r_pend_v;

   logic              w_tick;
   logic              w_apply;
   logic [DIG_W-1:0]  w_cd_nxt;
   logic [31:0]       w_disp_nxt;
   logic [7:0]        w_dp_nxt;
   logic [4:0]        w_shamt;
   logic [3:0]        w_nib;
   logic [6:0]        w_pat;
   logic              w_blank;
   logic [7:0]        w_seg_nxt;

   // seg is built from the post-tick index and content so cd and seg move together
   always_comb begin
      w_tick     = (r_pcnt == PCNT_MAX);
      w_apply    = w_tick && (cd == LAST_CD) && (r_pend_v || ld);
      w_cd_nxt   = cd + DIG_W'(1);
      w_disp_nxt = w_apply ? (ld ? din   : r_pend) : r_disp;
      w_dp_nxt   = w_apply ? (ld ? dp_in : r_pdp)  : r_dp_disp;
      w_shamt    = {w_cd_nxt, 2'b00};
      w_nib      = w_disp_nxt[w_shamt +: 4];
      w_blank    = blz && (w_cd_nxt != '0) && ((w_disp_nxt >> w_shamt) == 32'd0);
      w_seg_nxt  = {~w_dp_nxt[w_cd_nxt], (w_blank ? SEG_OFF : w_pat)};
   end

   hex7seg u_hex7seg (
      .nib (w_nib),
      .pat (w_pat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pcnt    <= '0;
         cd        <= '0;
         seg       <= SEG_BLANK;
         ack       <= 1'b0;
         r_disp    <= '0;
         r_dp_disp <= '0;
         r_pend    <= '0;
         r_pdp     <= '0;
         r_pend_v  <= 1'b0;
      end else begin
         r_pcnt <= w_tick ? '0 : r_pcnt + PCNT_W'(1);
         ack    <= w_apply;

         if (ld) begin
            r_pend <= din;
            r_pdp  <= dp_in;
         end

         // A load coincident with the apply is consumed directly, so pending clears
         if (w_apply)
            r_pend_v <= 1'b0;
         else if (ld)
            r_pend_v <= 1'b1;

         if (w_tick) begin
            cd        <= w_cd_nxt;
            seg       <= w_seg_nxt;
            r_disp    <= w_disp_nxt;
            r_dp_disp <= w_dp_nxt;
         end
      end
   end

endmodule

`default_nettype wire
